// File: rtl/ee354_gcd_arbiter.sv
// Round-robin sequencer that shares one ee354_GCD core among NREQ requesters.
// Define GCD_ARB_TIMEOUT_EN to add a WAIT watchdog that resets the core after TO_CYC cycles.
module ee354_gcd_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned W      = 8,
    parameter int unsigned TO_CYC = 1024
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*W-1:0] Req_A,
    input  logic [NREQ*W-1:0] Req_B,
    output logic [NREQ-1:0]   Gnt,
    output logic              Resp_Valid,
    output logic [2:0]        Resp_Id,
    output logic [W-1:0]      Resp_GCD,
    output logic [W-1:0]      Resp_Icount,
    output logic              Resp_Err,
    output logic [W-1:0]      Core_Ain,
    output logic [W-1:0]      Core_Bin,
    output logic              Core_Start,
    output logic              Core_Ack,
    output logic              Core_Reset,
    input  logic              Core_Done,
    input  logic [W-1:0]      Core_GCD,
    input  logic [W-1:0]      Core_Icount
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StAck, StResp} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   cur_id_q, cur_id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    ain_q, ain_d, bin_q, bin_d;
    logic [W-1:0]    res_gcd_q, res_gcd_d, res_icnt_q, res_icnt_d;
    logic            res_err_q, res_err_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   scan_idx;
    logic [W-1:0]    req_a_arr [NREQ];
    logic [W-1:0]    req_b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_a_arr[g] = Req_A[g*W +: W];
        assign req_b_arr[g] = Req_B[g*W +: W];
    end

    // First set request at or after ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            scan_idx = IW'((int'(ptr_q) + k) % int'(NREQ));
            if (!pick_valid && Req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          core_reset_q, core_reset_d;
`else
    logic unused_to_cyc;
    assign unused_to_cyc = (TO_CYC == 0);
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_id_d   = cur_id_q;
        gnt_d      = gnt_q;
        ain_d      = ain_q;
        bin_d      = bin_q;
        res_gcd_d  = res_gcd_q;
        res_icnt_d = res_icnt_q;
        res_err_d  = res_err_q;
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        core_reset_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d  = StLoad;
                    gnt_d    = NREQ'(1) << pick_idx;
                    cur_id_d = pick_idx;
                    ain_d    = req_a_arr[pick_idx];
                    bin_d    = req_b_arr[pick_idx];
                end
            end
            StLoad: begin
                if (ain_q == '0 || bin_q == '0) begin
                    res_err_d  = 1'b1;
                    res_gcd_d  = '0;
                    res_icnt_d = '0;
                    state_d    = StResp;
                end else begin
                    res_err_d = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
`ifdef GCD_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            StWait: begin
                if (Core_Done) begin
                    res_gcd_d  = Core_GCD;
                    res_icnt_d = Core_Icount;
                    res_err_d  = 1'b0;
                    state_d    = StAck;
                end
`ifdef GCD_ARB_TIMEOUT_EN
                // Pulse lands in RESP, TO_CYC cycles after entering WAIT; ACK is skipped.
                else if (cnt_q == CW'(TO_CYC - 1)) begin
                    core_reset_d = 1'b1;
                    res_err_d    = 1'b1;
                    res_gcd_d    = '0;
                    res_icnt_d   = '0;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StAck: begin
                state_d = StResp;
            end
            StResp: begin
                ptr_d   = (cur_id_q == IW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cur_id_q   <= '0;
            gnt_q      <= '0;
            ain_q      <= '0;
            bin_q      <= '0;
            res_gcd_q  <= '0;
            res_icnt_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_id_q   <= cur_id_d;
            gnt_q      <= gnt_d;
            ain_q      <= ain_d;
            bin_q      <= bin_d;
            res_gcd_q  <= res_gcd_d;
            res_icnt_q <= res_icnt_d;
            res_err_q  <= res_err_d;
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q        <= '0;
            core_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
        end
    end
    assign Core_Reset = core_reset_q;
`else
    assign Core_Reset = 1'b0;
`endif

    assign Gnt         = gnt_q;
    assign Core_Ain    = ain_q;
    assign Core_Bin    = bin_q;
    assign Core_Start  = (state_q == StStart);
    assign Core_Ack    = (state_q == StAck);
    assign Resp_Valid  = (state_q == StResp);
    assign Resp_Id     = 3'(cur_id_q);
    assign Resp_GCD    = res_gcd_q;
    assign Resp_Icount = res_icnt_q;
    assign Resp_Err    = res_err_q;

endmodule

// File: tb/tb_ee354_gcd_arbiter.sv
// Directed bench for ee354_gcd_arbiter with a behavioural GCD core model (programmable Done delay).
module tb_ee354_gcd_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic            Clk;
    logic            Reset_n;
    logic [NREQ-1:0] Req;
    logic [NREQ*W-1:0] Req_A, Req_B;
    logic [NREQ-1:0] Gnt;
    logic            Resp_Valid, Resp_Err;
    logic [2:0]      Resp_Id;
    logic [W-1:0]    Resp_GCD, Resp_Icount;
    logic [W-1:0]    Core_Ain, Core_Bin, Core_GCD, Core_Icount;
    logic            Core_Start, Core_Ack, Core_Reset, Core_Done;

    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    assign Req_A = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign Req_B = {op_b[3], op_b[2], op_b[1], op_b[0]};

    int compared   = 0;
    int mismatched = 0;

    ee354_gcd_arbiter #(.NREQ(NREQ), .W(W), .TO_CYC(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Req_A(Req_A), .Req_B(Req_B),
        .Gnt(Gnt), .Resp_Valid(Resp_Valid), .Resp_Id(Resp_Id), .Resp_GCD(Resp_GCD),
        .Resp_Icount(Resp_Icount), .Resp_Err(Resp_Err), .Core_Ain(Core_Ain),
        .Core_Bin(Core_Bin), .Core_Start(Core_Start), .Core_Ack(Core_Ack),
        .Core_Reset(Core_Reset), .Core_Done(Core_Done), .Core_GCD(Core_GCD),
        .Core_Icount(Core_Icount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Core model: Done rises 'delay' cycles after the Start cycle, held until Ack.
    int   delay = 3;
    bit   never_done = 1'b0;
    logic busy;
    int   mcnt;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = y;
            y = x % y;
            x = t;
        end
        return x;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy <= 1'b0;
            mcnt <= 0;
        end else if (Core_Reset || Core_Ack) begin
            busy <= 1'b0;
        end else if (Core_Start) begin
            busy <= 1'b1;
            mcnt <= 1;
        end else if (busy) begin
            mcnt <= mcnt + 1;
        end
    end

    assign Core_Done   = busy && !never_done && (mcnt >= delay);
    assign Core_GCD    = gcd_f(Core_Ain, Core_Bin);
    assign Core_Icount = W'(delay);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Continuous protocol checks.
    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("gnt_onehot0", 32'($onehot0(Gnt)), 1);
            chk("start_without_gnt", 32'(Core_Start && (Gnt == '0)), 0);
            chk("stale_done_at_start", 32'(Core_Start && Core_Done), 0);
        end
    end

    // Cycle n = n-th negedge after Req was driven in an IDLE cycle.
    task automatic run_job(input int limit, input int drop_at, output int t_start,
                           output int t_ack, output int t_resp, output int t_rst,
                           output logic [NREQ-1:0] gnt1, output logic [W-1:0] ain1);
        t_start = 0;
        t_ack   = 0;
        t_resp  = 0;
        t_rst   = 0;
        gnt1    = '0;
        ain1    = '0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge Clk);
            if (n == 1) begin
                gnt1 = Gnt;
                ain1 = Core_Ain;
            end
            if (Core_Start && t_start == 0) t_start = n;
            if (Core_Ack && t_ack == 0) t_ack = n;
            if (Core_Reset && t_rst == 0) t_rst = n;
            if (n == drop_at) Req = '0;
            if (Resp_Valid) begin
                t_resp = n;
                if (drop_at == 0) Req = '0;
                break;
            end
        end
        if (t_resp == 0) chk("resp_within_budget", 32'(Resp_Valid), 1);
    endtask

    int exp_rot_id  [5] = '{0, 1, 2, 3, 0};
    int exp_rot_gcd [5] = '{12, 7, 3, 5, 12};

    initial begin
        int ts, ta, tr, trs;
        logic [NREQ-1:0] g1;
        logic [W-1:0] a1;

        Reset_n = 1'b0;
        Req     = '0;
        op_a[0] = 8'd36; op_b[0] = 8'd24;
        op_a[1] = 8'd21; op_b[1] = 8'd14;
        op_a[2] = 8'd9;  op_b[2] = 8'd6;
        op_a[3] = 8'd15; op_b[3] = 8'd10;
        #12;
        chk("rst_gnt", 32'(Gnt), 0);
        chk("rst_resp", 32'({Resp_Valid, Resp_Id, Resp_GCD, Resp_Icount, Resp_Err}), 0);
        chk("rst_core", 32'({Core_Ain, Core_Bin, Core_Start, Core_Ack, Core_Reset}), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("idle_valid", 32'(Resp_Valid), 0);

        // Fairness: all requests held, grants rotate 0,1,2,3,0.
        delay = 3;
        Req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_job(100, (i == 4) ? 0 : -1, ts, ta, tr, trs, g1, a1);
            chk("rot_id", 32'(Resp_Id), 32'(exp_rot_id[i]));
            chk("rot_gcd", 32'(Resp_GCD), 32'(exp_rot_gcd[i]));
        end

        // Single job, Done 10 cycles after Start.
        @(negedge Clk);
        delay = 10;
        Req = 4'b0001;
        run_job(100, 0, ts, ta, tr, trs, g1, a1);
        chk("t1_gnt_c1", 32'(g1), 32'b0001);
        chk("t1_ain_c1", 32'(a1), 36);
        chk("t1_start_cyc", 32'(ts), 2);
        chk("t1_ack_cyc", 32'(ta), 13);
        chk("t1_resp_cyc", 32'(tr), 14);
        chk("t1_id", 32'(Resp_Id), 0);
        chk("t1_gcd", 32'(Resp_GCD), 12);
        chk("t1_icount", 32'(Resp_Icount), 10);
        chk("t1_err", 32'(Resp_Err), 0);

        // Zero operand: error response at cycle 2, no Start.
        @(negedge Clk);
        op_a[2] = 8'd0; op_b[2] = 8'd5;
        Req = 4'b0100;
        run_job(20, 0, ts, ta, tr, trs, g1, a1);
        chk("t3_resp_cyc", 32'(tr), 2);
        chk("t3_no_start", 32'(ts), 0);
        chk("t3_id", 32'(Resp_Id), 2);
        chk("t3_err", 32'(Resp_Err), 1);
        chk("t3_gcd", 32'(Resp_GCD), 0);
        chk("t3_icount", 32'(Resp_Icount), 0);
        op_a[2] = 8'd9; op_b[2] = 8'd6;

        // Reset in WAIT; pointer (3 before reset) must restart from 0.
        @(negedge Clk);
        delay = 10;
        Req = 4'b0001;
        for (int n = 0; n < 4; n++) @(negedge Clk);
        chk("t4_gnt_pre", 32'(Gnt), 32'b0001);
        Reset_n = 1'b0;
        Req = '0;
        #1;
        chk("t4_gnt", 32'(Gnt), 0);
        chk("t4_resp", 32'({Resp_Valid, Resp_Id, Resp_GCD, Resp_Icount, Resp_Err}), 0);
        chk("t4_core", 32'({Core_Ain, Core_Bin, Core_Start, Core_Ack, Core_Reset}), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        delay = 3;
        Req = 4'b1110;
        run_job(100, 0, ts, ta, tr, trs, g1, a1);
        chk("t4_first_id", 32'(Resp_Id), 1);
        chk("t4_gcd", 32'(Resp_GCD), 7);

        // Req dropped one cycle after LOAD; job still completes.
        @(negedge Clk);
        delay = 4;
        Req = 4'b1000;
        run_job(100, 2, ts, ta, tr, trs, g1, a1);
        chk("t6_resp_cyc", 32'(tr), 8);
        chk("t6_id", 32'(Resp_Id), 3);
        chk("t6_gcd", 32'(Resp_GCD), 5);
        chk("t6_err", 32'(Resp_Err), 0);

`ifdef GCD_ARB_TIMEOUT_EN
        // Watchdog: Done never arrives, TO_CYC=16.
        @(negedge Clk);
        never_done = 1'b1;
        Req = 4'b0001;
        run_job(100, 0, ts, ta, tr, trs, g1, a1);
        chk("t5_rst_cyc", 32'(trs), 19);
        chk("t5_resp_cyc", 32'(tr), 19);
        chk("t5_no_ack", 32'(ta), 0);
        chk("t5_err", 32'(Resp_Err), 1);
        chk("t5_gcd", 32'(Resp_GCD), 0);
        never_done = 1'b0;
        @(negedge Clk);
        delay = 3;
        Req = 4'b0010;
        run_job(100, 0, ts, ta, tr, trs, g1, a1);
        chk("t5_next_resp_cyc", 32'(tr), 7);
        chk("t5_next_id", 32'(Resp_Id), 1);
        chk("t5_next_gcd", 32'(Resp_GCD), 7);
        chk("t5_next_err", 32'(Resp_Err), 0);
`endif

        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
